// File: rtl/bbc_keyboard.sv
// bbc_keyboard: VIA port A / CA2 keyboard matrix responder with autoscan and manual key query.
// Optional build macro KBD_LINKS_EN makes row 0 of columns 2..9 read-only and return the LINKS byte.
module bbc_keyboard #(
    parameter logic [7:0] LINKS = 8'h00,
    parameter int         NCOLS = 10
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       kb_nwe,
    input  logic [6:0] pa_in,
    output logic       pa7,
    output logic       ca2,
    input  logic       key_stb,
    input  logic [6:0] key_code,
    input  logic       key_make,
    output logic       key_any
);
    logic [7:0] mat_q [NCOLS];
    logic [7:0] mat_d [NCOLS];
    logic [7:0] view [16];
    logic [3:0] scan_col_q, scan_col_d;
    logic       ca2_q, ca2_d, key_any_q, key_any_d;

    // Visible matrix: empty columns read 0, link cells overlay the stored (always-zero) bit.
    for (genvar c = 0; c < 16; c++) begin : g_col
        if (c >= NCOLS) begin : g_empty
            assign view[c] = 8'h00;
`ifdef KBD_LINKS_EN
        end else if (c >= 2 && c <= 9) begin : g_link
            assign view[c] = mat_q[c] | {7'h00, LINKS[9-c]};
`endif
        end else begin : g_store
            assign view[c] = mat_q[c];
        end
    end

    // Next-state for matrix, scan column, interrupt and any-key summary.
    always_comb begin
        mat_d = mat_q;
        for (int i = 0; i < NCOLS; i++)
            if (key_stb && key_code[3:0] == 4'(i)
`ifdef KBD_LINKS_EN
                && !(i >= 2 && i <= 9 && key_code[6:4] == 3'd0)
`endif
            ) mat_d[i][key_code[6:4]] = key_make;
        scan_col_d = !clk_en ? scan_col_q :
                     !kb_nwe ? pa_in[3:0] :
                     (scan_col_q >= 4'(NCOLS-1)) ? 4'd0 : scan_col_q + 4'd1;
        ca2_d = clk_en ? |view[scan_col_q][7:1] : ca2_q;
        key_any_d = 1'b0;
        for (int i = 0; i < 16; i++) key_any_d = key_any_d | (|view[i][7:1]);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            mat_q      <= '{default: '0};
            scan_col_q <= 4'd0;
            ca2_q      <= 1'b0;
            key_any_q  <= 1'b0;
        end else begin
            mat_q      <= mat_d;
            scan_col_q <= scan_col_d;
            ca2_q      <= ca2_d;
            key_any_q  <= key_any_d;
        end
    end

    assign pa7     = nRESET & ~kb_nwe & view[pa_in[3:0]][pa_in[6:4]];
    assign ca2     = ca2_q;
    assign key_any = key_any_q;
endmodule

// File: tb/tb_bbc_keyboard.sv
// tb_bbc_keyboard: randomized and directed check of bbc_keyboard against a behavioural matrix model.
module tb_bbc_keyboard;
    logic       clk = 1'b0, nRESET = 1'b0, clk_en = 1'b0, kb_nwe = 1'b1;
    logic [6:0] pa_in = 7'h00, key_code = 7'h00;
    logic       key_stb = 1'b0, key_make = 1'b0;
    logic       pa7, ca2, key_any;
    logic [7:0] lk = 8'hA5;
    int         tests = 0, fails = 0;
    bit         mdl [16][8];
    int         scol = 0;
    bit         mca2 = 0, many = 0;

    bbc_keyboard #(.LINKS(8'hA5), .NCOLS(10)) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .kb_nwe(kb_nwe), .pa_in(pa_in),
        .pa7(pa7), .ca2(ca2), .key_stb(key_stb), .key_code(key_code),
        .key_make(key_make), .key_any(key_any)
    );

    always #5 clk = ~clk;

    function automatic bit col_down(int c);
        if (c >= 10) return 0;
        for (int r = 1; r < 8; r++) if (mdl[c][r]) return 1;
        return 0;
    endfunction

    function automatic bit link_cell(int c, int r);
`ifdef KBD_LINKS_EN
        return r == 0 && c >= 2 && c <= 9;
`else
        return 0;
`endif
    endfunction

    function automatic bit exp_pa7();
        int c = int'(pa_in[3:0]);
        int r = int'(pa_in[6:4]);
        if (!nRESET || kb_nwe || c >= 10) return 0;
        if (link_cell(c, r)) return lk[9-c];
        return mdl[c][r];
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".ca2"}, ca2, mca2);
        chk({tag, ".key_any"}, key_any, many);
        chk({tag, ".pa7"}, pa7, exp_pa7());
    endtask

    task automatic tick(bit en, bit stb, logic [6:0] code, bit mk, string tag);
        bit any_old;
        clk_en = en; key_stb = stb; key_code = code; key_make = mk;
        @(posedge clk);
        if (!nRESET) begin
            foreach (mdl[c, r]) mdl[c][r] = 0;
            scol = 0; mca2 = 0; many = 0;
        end else begin
            any_old = 0;
            for (int c = 0; c < 10; c++) any_old |= col_down(c);
            many = any_old;
            if (en) begin
                mca2 = col_down(scol);
                scol = kb_nwe ? ((scol >= 9) ? 0 : scol + 1) : int'(pa_in[3:0]);
            end
            if (stb && code[3:0] < 10 && !link_cell(int'(code[3:0]), int'(code[6:4])))
                mdl[code[3:0]][code[6:4]] = mk;
        end
        #1;
        clk_en = 1'b0; key_stb = 1'b0;
        chk_all(tag);
    endtask

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) tick((i % 3) == 2, 1'b0, 7'h00, 1'b0, tag);
    endtask

    initial begin
        nRESET = 1'b0;
        run(3, "reset");
        nRESET = 1'b1;
        run(75, "idle_scan");
        tick(1'b0, 1'b1, 7'h42, 1'b1, "make42");
        chk("key_any_after_make", key_any, 1'b0);
        tick(1'b0, 1'b0, 7'h00, 1'b0, "make42_next");
        chk("key_any_one_clk", key_any, 1'b1);
        run(45, "scan42");
        kb_nwe = 1'b0; pa_in = 7'h42; #1;
        chk("pa7_42", pa7, 1'b1);
        pa_in = 7'h43; #1;
        chk("pa7_43", pa7, 1'b0);
        pa_in = 7'h42;
        tick(1'b0, 1'b1, 7'h42, 1'b0, "break42");
        chk("pa7_after_break", pa7, 1'b0);
        tick(1'b0, 1'b1, 7'h3C, 1'b1, "make3C");
        pa_in = 7'h0C;
        run(9, "manual_C");
        kb_nwe = 1'b1;
        run(12, "resume_C");
        tick(1'b0, 1'b1, 7'h11, 1'b1, "make11");
        for (int i = 0; i < 30; i++) tick(1'b1, (scol == 1), 7'h11, 1'b0, "coincident");
        tick(1'b0, 1'b1, 7'h1B, 1'b1, "colB");
        chk("colB_any", key_any, 1'b0);
        kb_nwe = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            pa_in = 7'(c); #1;
`ifdef KBD_LINKS_EN
            chk("links_row0", pa7, lk[9-c]);
`else
            chk("plain_row0", pa7, 1'b0);
`endif
        end
        pa_in = 7'h05;
        tick(1'b0, 1'b1, 7'h05, 1'b1, "make05");
`ifdef KBD_LINKS_EN
        chk("links_05_ro", pa7, 1'b0);
`else
        chk("plain_05", pa7, 1'b1);
`endif
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) kb_nwe = ~kb_nwe;
            nRESET = ($urandom_range(0, 149) != 0);
            pa_in = 7'($urandom);
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 7'($urandom),
                 1'($urandom), "random");
        end
        nRESET = 1'b0;
        tick(1'b1, 1'b0, 7'h00, 1'b0, "final_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
